trap_csr_unit: RTL and testbench
================================

Name: trap_csr_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the Lagarto Hun core.
- Replaces the fixed-width CSR-only handler. Adds registered CSR reads, trap entry/exit sequencing (exceptions, interrupts, MRET), direct/vectored mtvec dispatch, and a configurable interrupt-line count.
- Sits between the core's execute/commit stage and the fetch redirect path.

Parameters:
- XLEN, 32, data width of all CSRs and PCs (32 or 64).
- IRQ_COUNT, 16, number of local interrupt lines. Range 1..XLEN-1. Line k maps to mip/mie bit k and to cause code k.
- CAUSE_WIDTH, 5, width of the synchronous exception cause input.

Ports:
- clock_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- csr_address_i  in  12  CSR address.
- csr_command_i  in  2  00 none, 01 read, 10 write, 11 write-and-read.
- csr_write_data_i  in  XLEN  write data.
- csr_ready_o  out  1  CSR command accepted this cycle.
- csr_read_data_o  out  XLEN  read data, registered.
- csr_read_data_valid_o  out  1  one-cycle pulse qualifying csr_read_data_o.
- csr_illegal_o  out  1  one-cycle pulse, illegal access.
- exception_i  in  1  synchronous exception at commit.
- exception_cause_i  in  CAUSE_WIDTH  exception cause code.
- exception_pc_i  in  XLEN  PC of faulting instruction, or next PC for an interrupt.
- exception_tval_i  in  XLEN  trap value.
- mret_i  in  1  MRET committed.
- irq_i  in  IRQ_COUNT  level-sensitive interrupt lines.
- trap_valid_o  out  1  redirect request.
- trap_pc_o  out  XLEN  redirect target.
- trap_ack_i  in  1  fetch accepted the redirect.

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. mstatus=0x1800 (MPP=11, MIE=0, MPIE=0). mie, mip, mtvec, mscratch, mepc, mcause and mtval are 0. misa is constant: MXL from XLEN, 'I' bit set.
- Reset mid-operation aborts any trap or redirect immediately; trap_valid_o falls asynchronously.
- Implemented CSRs: mstatus (MIE bit3, MPIE bit7 writable; MPP read-only 11), misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip.
  - mie: only bits IRQ_COUNT-1:0 writable.
  - mip: read-only; writes to it are ignored without flagging illegal.
  - mepc: bit 1:0 forced 0.
  - mtvec: mode 2 or 3 written keeps the previous mode; base is always written.
- csr_ready_o = (state==IDLE) && !exception_i && !mret_i. Commands issued while csr_ready_o=0 are dropped.
- CSR write: takes effect at the accepting clock edge.
- CSR read: data and valid pulse appear one cycle after acceptance. Write-and-read returns the pre-write value.
- Illegal access: unimplemented address, or a write to address[11:10]==11. csr_illegal_o pulses one cycle after acceptance, csr_read_data_valid_o stays 0, and no state changes.
- mip sampling: irq_i registered once into mip each cycle.
- Pending interrupt: (mip & mie) != 0 && mstatus.MIE. The highest-index pending line wins.
- FSM states: IDLE, SAVE, REDIRECT.
- IDLE priority: exception_i > mret_i > pending interrupt.
  - Exception or interrupt -> SAVE.
  - MRET -> REDIRECT, with MIE<=MPIE, MPIE<=1, trap_pc_o<=mepc.
- SAVE (1 cycle):
  - mepc <= exception_pc_i (captured at the IDLE cycle).
  - mcause <= {0, cause} for an exception, {1, index} for an interrupt.
  - mtval <= tval for an exception, 0 for an interrupt.
  - MPIE<=MIE, MIE<=0.
  - Target = base for an exception or direct mode; base + 4*index for an interrupt in vectored mode. Arithmetic is modulo 2^XLEN.
  - Next state: REDIRECT.
- REDIRECT: trap_valid_o=1 with trap_pc_o stable until a cycle with trap_ack_i=1, then IDLE. If trap_ack_i is already high on the first REDIRECT cycle, it is a 1-cycle state.
- Latency: exception_i at cycle N gives trap_valid_o at N+2; mret_i at cycle N gives trap_valid_o at N+1.
- exception_i and mret_i are ignored outside IDLE. The core must hold commit until the acknowledge.

Optional Feature:
- Macro: TRAP_CSR_MCYCLE_EN.
- Defined:
  - Adds a 64-bit mcycle counter that increments every cycle, wraps 2^64-1 -> 0, and resets to 0.
  - Readable and writable at 0xB00 (low XLEN bits). For XLEN=32, 0xB80 holds the high half.
  - A CSR write overrides the increment in that cycle.
- Undefined: 0xB00/0xB80 are unimplemented and access raises csr_illegal_o.

Test Plan:
- Write 0x5A5A5A5A to mscratch (0x340), then write-and-read 0x1 -> read returns 0x5A5A5A5A one cycle later, valid pulse 1 cycle; following read returns 0x1.
- Read 0x7C0 -> csr_illegal_o pulse, csr_read_data_valid_o=0. Write 0xF14 -> illegal, no state change.
- mtvec=0x1000 direct, exception_i with cause 2, pc 0x200, tval 0xDEAD -> trap_valid_o at N+2 with trap_pc_o=0x1000; mepc=0x200, mcause=2, mtval=0xDEAD, MIE=0; hold 3 cycles without ack, then ack -> IDLE.
- mtvec=0x1001 vectored, mie=0x0088, MIE=1, irq_i[3] and irq_i[7] high -> mcause=0x80000007, trap_pc_o=0x101C. Then mret_i -> trap_pc_o=mepc, MIE=1.
- exception_i, mret_i and a CSR write in the same cycle -> exception taken, csr_ready_o=0, CSR unchanged; reset_i asserted during REDIRECT -> trap_valid_o=0 immediately, mstatus=0x1800.
- TRAP_CSR_MCYCLE_EN, XLEN=32: write 0xFFFFFFFF to 0xB00 -> next cycle 0xB80 reads 1 (carry into the high half).

Source files
------------

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap controller (exception/interrupt entry, MRET, mtvec dispatch).
// Optional 64-bit mcycle counter at 0xB00/0xB80 when TRAP_CSR_MCYCLE_EN is defined.
module trap_csr_unit #(
  parameter int XLEN        = 32,
  parameter int IRQ_COUNT   = 16,
  parameter int CAUSE_WIDTH = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [11:0]            csr_address_i,
  input  logic [1:0]             csr_command_i,
  input  logic [XLEN-1:0]        csr_write_data_i,
  output logic                   csr_ready_o,
  output logic [XLEN-1:0]        csr_read_data_o,
  output logic                   csr_read_data_valid_o,
  output logic                   csr_illegal_o,
  input  logic                   exception_i,
  input  logic [CAUSE_WIDTH-1:0] exception_cause_i,
  input  logic [XLEN-1:0]        exception_pc_i,
  input  logic [XLEN-1:0]        exception_tval_i,
  input  logic                   mret_i,
  input  logic [IRQ_COUNT-1:0]   irq_i,
  output logic                   trap_valid_o,
  output logic [XLEN-1:0]        trap_pc_o,
  input  logic                   trap_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam int IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  state_t                  r_state;
  logic                    r_mstatus_mie;
  logic                    r_mstatus_mpie;
  logic [IRQ_COUNT-1:0]    r_mie;
  logic [IRQ_COUNT-1:0]    r_mip;
  logic [XLEN-1:0]         r_mtvec;
  logic [XLEN-1:0]         r_mscratch;
  logic [XLEN-1:0]         r_mepc;
  logic [XLEN-1:0]         r_mcause;
  logic [XLEN-1:0]         r_mtval;
  logic [XLEN-1:0]         r_pc_cap;
  logic [XLEN-1:0]         r_tval_cap;
  logic [CAUSE_WIDTH-1:0]  r_cause_cap;
  logic                    r_is_irq;
  logic [IDX_W-1:0]        r_irq_idx;
  logic                    r_trap_valid;
  logic [XLEN-1:0]         r_trap_pc;
  logic [XLEN-1:0]         r_rdata;
  logic                    r_rvalid;
  logic                    r_illegal;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_addr_ok;
  logic                    w_illegal;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic [XLEN-1:0]         w_read_val;
  logic [XLEN-1:0]         w_mstatus;
  logic [XLEN-1:0]         w_misa;
  logic [XLEN-1:0]         w_mtvec_next;
  logic [IRQ_COUNT-1:0]    w_pend_vec;
  logic                    w_pending;
  logic [IDX_W-1:0]        w_irq_idx;
  logic [XLEN-1:0]         w_base;
  logic [XLEN-1:0]         w_trap_target;
  logic [XLEN-1:0]         w_irq_cause;

`ifdef TRAP_CSR_MCYCLE_EN
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;
  logic [63:0] r_mcycle;
  logic [63:0] w_wdata64;
  assign w_wdata64 = 64'(csr_write_data_i);
`endif

  assign w_ready   = (r_state == ST_IDLE) && !exception_i && !mret_i && !reset_i;
  assign w_accept  = w_ready && (csr_command_i != 2'b00);
  assign w_illegal = !w_addr_ok || (csr_command_i[1] && (csr_address_i[11:10] == 2'b11));
  assign w_wr_en   = w_accept && csr_command_i[1] && !w_illegal;
  assign w_rd_en   = w_accept && csr_command_i[0] && !w_illegal;

  assign w_pend_vec = r_mip & r_mie;
  assign w_pending  = (|w_pend_vec) && r_mstatus_mie;
  assign w_base     = {r_mtvec[XLEN-1:2], 2'b00};
  // A mode of 2 or 3 is reserved, so the old mode survives such a write.
  assign w_mtvec_next = {csr_write_data_i[XLEN-1:2],
                         csr_write_data_i[1] ? r_mtvec[1:0] : csr_write_data_i[1:0]};

  // Constant and composed CSR views.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_misa           = '0;
    w_misa[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
    w_misa[8]        = 1'b1;
    w_irq_cause      = XLEN'(r_irq_idx);
    w_irq_cause[XLEN-1] = 1'b1;
  end

  // Highest-index pending line wins.
  always_comb begin
    w_irq_idx = '0;
    for (int k = 0; k < IRQ_COUNT; k++) begin
      w_irq_idx = w_pend_vec[k] ? IDX_W'(k) : w_irq_idx;
    end
  end

  // Trap target: vectored dispatch only for interrupts.
  always_comb begin
    if (r_is_irq && (r_mtvec[1:0] == 2'b01)) begin
      w_trap_target = w_base + (XLEN'(r_irq_idx) << 2);
    end else begin
      w_trap_target = w_base;
    end
  end

  // CSR read mux and address decode.
  always_comb begin
    w_read_val = '0;
    w_addr_ok  = 1'b1;
    case (csr_address_i)
      A_MSTATUS:  w_read_val = w_mstatus;
      A_MISA:     w_read_val = w_misa;
      A_MIE:      w_read_val = XLEN'(r_mie);
      A_MTVEC:    w_read_val = r_mtvec;
      A_MSCRATCH: w_read_val = r_mscratch;
      A_MEPC:     w_read_val = r_mepc;
      A_MCAUSE:   w_read_val = r_mcause;
      A_MTVAL:    w_read_val = r_mtval;
      A_MIP:      w_read_val = XLEN'(r_mip);
`ifdef TRAP_CSR_MCYCLE_EN
      A_MCYCLE:   w_read_val = XLEN'(r_mcycle);
      A_MCYCLEH: begin
        if (XLEN == 32) begin
          w_read_val = XLEN'(r_mcycle[63:32]);
        end else begin
          w_addr_ok = 1'b0;
        end
      end
`endif
      default:    w_addr_ok = 1'b0;
    endcase
  end

  // Trap FSM together with the CSRs it shares with the write port.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= ST_IDLE;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_pc_cap       <= '0;
      r_tval_cap     <= '0;
      r_cause_cap    <= '0;
      r_is_irq       <= 1'b0;
      r_irq_idx      <= '0;
      r_trap_valid   <= 1'b0;
      r_trap_pc      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exception_i) begin
            r_pc_cap    <= exception_pc_i;
            r_cause_cap <= exception_cause_i;
            r_tval_cap  <= exception_tval_i;
            r_is_irq    <= 1'b0;
            r_state     <= ST_SAVE;
          end else if (mret_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            r_trap_pc      <= r_mepc;
            r_trap_valid   <= 1'b1;
            r_state        <= ST_REDIRECT;
          end else if (w_pending) begin
            r_pc_cap  <= exception_pc_i;
            r_is_irq  <= 1'b1;
            r_irq_idx <= w_irq_idx;
            r_state   <= ST_SAVE;
          end else begin
            r_state <= ST_IDLE;
          end
          // Only the interrupt path can coincide with a write; SAVE overwrites next cycle.
          if (w_wr_en) begin
            case (csr_address_i)
              A_MSTATUS: begin
                r_mstatus_mie  <= csr_write_data_i[3];
                r_mstatus_mpie <= csr_write_data_i[7];
              end
              A_MEPC:   r_mepc   <= {csr_write_data_i[XLEN-1:2], 2'b00};
              A_MCAUSE: r_mcause <= csr_write_data_i;
              A_MTVAL:  r_mtval  <= csr_write_data_i;
              default:  r_mtval  <= r_mtval;
            endcase
          end
        end
        ST_SAVE: begin
          r_mepc         <= {r_pc_cap[XLEN-1:2], 2'b00};
          r_mcause       <= r_is_irq ? w_irq_cause : XLEN'(r_cause_cap);
          r_mtval        <= r_is_irq ? '0 : r_tval_cap;
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
          r_trap_pc      <= w_trap_target;
          r_trap_valid   <= 1'b1;
          r_state        <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (trap_ack_i) begin
            r_trap_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_REDIRECT;
          end
        end
        default: begin
          r_trap_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Remaining CSRs, interrupt sampling and the registered read port.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_mie      <= '0;
      r_mip      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_mip     <= irq_i;
      r_rvalid  <= w_rd_en;
      r_illegal <= w_accept && w_illegal;
      r_rdata   <= w_rd_en ? w_read_val : '0;
      if (w_wr_en) begin
        case (csr_address_i)
          A_MIE:      r_mie      <= csr_write_data_i[IRQ_COUNT-1:0];
          A_MTVEC:    r_mtvec    <= w_mtvec_next;
          A_MSCRATCH: r_mscratch <= csr_write_data_i;
          default:    r_mscratch <= r_mscratch;
        endcase
      end
    end
  end

`ifdef TRAP_CSR_MCYCLE_EN
  // Free-running cycle counter; a CSR write replaces the increment.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_mcycle <= 64'd0;
    end else if (w_wr_en && (csr_address_i == A_MCYCLE)) begin
      if (XLEN == 32) begin
        r_mcycle <= {r_mcycle[63:32], w_wdata64[31:0]};
      end else begin
        r_mcycle <= w_wdata64;
      end
    end else if (w_wr_en && (csr_address_i == A_MCYCLEH)) begin
      r_mcycle <= {w_wdata64[31:0], r_mcycle[31:0]};
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end
`endif

  assign csr_ready_o           = w_ready;
  assign csr_read_data_o       = r_rdata;
  assign csr_read_data_valid_o = r_rvalid;
  assign csr_illegal_o         = r_illegal;
  assign trap_valid_o          = r_trap_valid;
  assign trap_pc_o             = r_trap_pc;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed self-checking bench for trap_csr_unit (default parameters, XLEN=32, IRQ_COUNT=16).
module tb_trap_csr_unit;

  logic        clk;
  logic        reset_i;
  logic [11:0] csr_address_i;
  logic [1:0]  csr_command_i;
  logic [31:0] csr_write_data_i;
  logic        csr_ready_o;
  logic [31:0] csr_read_data_o;
  logic        csr_read_data_valid_o;
  logic        csr_illegal_o;
  logic        exception_i;
  logic [4:0]  exception_cause_i;
  logic [31:0] exception_pc_i;
  logic [31:0] exception_tval_i;
  logic        mret_i;
  logic [15:0] irq_i;
  logic        trap_valid_o;
  logic [31:0] trap_pc_o;
  logic        trap_ack_i;

  int vecs = 0;
  int errs = 0;
  logic [31:0] rd;
  logic        rv;
  logic        ill;

  trap_csr_unit dut (
    .clock_i(clk), .reset_i(reset_i),
    .csr_address_i(csr_address_i), .csr_command_i(csr_command_i),
    .csr_write_data_i(csr_write_data_i), .csr_ready_o(csr_ready_o),
    .csr_read_data_o(csr_read_data_o), .csr_read_data_valid_o(csr_read_data_valid_o),
    .csr_illegal_o(csr_illegal_o), .exception_i(exception_i),
    .exception_cause_i(exception_cause_i), .exception_pc_i(exception_pc_i),
    .exception_tval_i(exception_tval_i), .mret_i(mret_i), .irq_i(irq_i),
    .trap_valid_o(trap_valid_o), .trap_pc_o(trap_pc_o), .trap_ack_i(trap_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic csr_op(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] o_rd, output logic o_rv, output logic o_ill);
    csr_command_i = cmd; csr_address_i = addr; csr_write_data_i = wd;
    @(posedge clk); #1;
    csr_command_i = 2'b00;
    o_rd = csr_read_data_o; o_rv = csr_read_data_valid_o; o_ill = csr_illegal_o;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({trap_valid_o, csr_read_data_valid_o, csr_illegal_o, csr_ready_o} !== 4'b0000) begin
      errs++; $display("FAIL reset_outs: got %b expected 0000", {trap_valid_o, csr_read_data_valid_o, csr_illegal_o, csr_ready_o}); end
    vecs++; if ({trap_pc_o, csr_read_data_o} !== 64'd0) begin
      errs++; $display("FAIL reset_data: got %h/%h expected 0", trap_pc_o, csr_read_data_o); end
    reset_i = 1'b0; #1;
    vecs++; if (csr_ready_o !== 1'b1) begin errs++; $display("FAIL ready_idle: got %b expected 1", csr_ready_o); end
    csr_op(2'b01, 12'h300, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00001800 || rv !== 1'b1) begin
      errs++; $display("FAIL reset_mstatus: got %h v=%b expected 00001800 v=1", rd, rv); end
    csr_op(2'b01, 12'h301, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h40000100) begin errs++; $display("FAIL misa: got %h expected 40000100", rd); end
    csr_op(2'b01, 12'h305, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL reset_mtvec: got %h expected 0", rd); end
  endtask

  task automatic test_rw_scratch();
    csr_op(2'b10, 12'h340, 32'h5A5A5A5A, rd, rv, ill);
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL write_no_valid: got %b expected 0", rv); end
    csr_op(2'b11, 12'h340, 32'h00000001, rd, rv, ill);
    vecs++; if (rd !== 32'h5A5A5A5A || rv !== 1'b1) begin
      errs++; $display("FAIL wr_rd_old: got %h v=%b expected 5a5a5a5a v=1", rd, rv); end
    @(posedge clk); #1;
    vecs++; if (csr_read_data_valid_o !== 1'b0) begin errs++; $display("FAIL valid_pulse: got %b expected 0", csr_read_data_valid_o); end
    csr_op(2'b01, 12'h340, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00000001) begin errs++; $display("FAIL scratch_new: got %h expected 00000001", rd); end
    csr_op(2'b10, 12'h304, 32'hFFFFFFFF, rd, rv, ill);
    csr_op(2'b01, 12'h304, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h0000FFFF) begin errs++; $display("FAIL mie_mask: got %h expected 0000ffff", rd); end
    csr_op(2'b10, 12'h341, 32'h00000123, rd, rv, ill);
    csr_op(2'b01, 12'h341, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00000120) begin errs++; $display("FAIL mepc_align: got %h expected 00000120", rd); end
  endtask

  task automatic test_mtvec_mode();
    csr_op(2'b10, 12'h305, 32'h00001001, rd, rv, ill);
    csr_op(2'b10, 12'h305, 32'h00002002, rd, rv, ill);
    csr_op(2'b01, 12'h305, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00002001) begin errs++; $display("FAIL mtvec_keep2: got %h expected 00002001", rd); end
    csr_op(2'b10, 12'h305, 32'h00003003, rd, rv, ill);
    csr_op(2'b01, 12'h305, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00003001) begin errs++; $display("FAIL mtvec_keep3: got %h expected 00003001", rd); end
    csr_op(2'b10, 12'h305, 32'h00001000, rd, rv, ill);
    csr_op(2'b01, 12'h305, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00001000) begin errs++; $display("FAIL mtvec_direct: got %h expected 00001000", rd); end
  endtask

  task automatic test_illegal();
    csr_op(2'b01, 12'h7C0, 32'd0, rd, rv, ill);
    vecs++; if (ill !== 1'b1 || rv !== 1'b0) begin
      errs++; $display("FAIL illegal_read: got ill=%b v=%b expected ill=1 v=0", ill, rv); end
    @(posedge clk); #1;
    vecs++; if (csr_illegal_o !== 1'b0) begin errs++; $display("FAIL illegal_pulse: got %b expected 0", csr_illegal_o); end
    csr_op(2'b10, 12'hF14, 32'hFFFFFFFF, rd, rv, ill);
    vecs++; if (ill !== 1'b1) begin errs++; $display("FAIL illegal_write_ro: got %b expected 1", ill); end
    csr_op(2'b11, 12'hC00, 32'h0, rd, rv, ill);
    vecs++; if (ill !== 1'b1 || rv !== 1'b0) begin
      errs++; $display("FAIL illegal_rw_c00: got ill=%b v=%b expected ill=1 v=0", ill, rv); end
    csr_op(2'b10, 12'h344, 32'hFFFFFFFF, rd, rv, ill);
    vecs++; if (ill !== 1'b0) begin errs++; $display("FAIL mip_write_legal: got %b expected 0", ill); end
    csr_op(2'b01, 12'h344, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL mip_ro: got %h expected 0", rd); end
    csr_op(2'b01, 12'h340, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00000001) begin errs++; $display("FAIL illegal_nochange: got %h expected 00000001", rd); end
`ifdef TRAP_CSR_MCYCLE_EN
    csr_op(2'b10, 12'hB80, 32'h0, rd, rv, ill);
    csr_op(2'b10, 12'hB00, 32'hFFFFFFFF, rd, rv, ill);
    @(posedge clk); #1;
    csr_op(2'b01, 12'hB80, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h00000001 || ill !== 1'b0) begin
      errs++; $display("FAIL mcycle_carry: got %h ill=%b expected 00000001 ill=0", rd, ill); end
`else
    csr_op(2'b01, 12'hB00, 32'd0, rd, rv, ill);
    vecs++; if (ill !== 1'b1) begin errs++; $display("FAIL mcycle_absent_lo: got %b expected 1", ill); end
    csr_op(2'b01, 12'hB80, 32'd0, rd, rv, ill);
    vecs++; if (ill !== 1'b1) begin errs++; $display("FAIL mcycle_absent_hi: got %b expected 1", ill); end
`endif
  endtask

  task automatic test_exception();
    csr_op(2'b10, 12'h300, 32'h00000008, rd, rv, ill);
    exception_i = 1'b1; exception_cause_i = 5'd2; exception_pc_i = 32'h200; exception_tval_i = 32'hDEAD;
    #1;
    vecs++; if (csr_ready_o !== 1'b0) begin errs++; $display("FAIL exc_ready: got %b expected 0", csr_ready_o); end
    @(posedge clk); #1;
    exception_i = 1'b0;
    vecs++; if (trap_valid_o !== 1'b0 || csr_ready_o !== 1'b0) begin
      errs++; $display("FAIL exc_n1: got valid=%b ready=%b expected 0/0", trap_valid_o, csr_ready_o); end
    @(posedge clk); #1;
    vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h1000) begin
      errs++; $display("FAIL exc_n2: got valid=%b pc=%h expected 1/00001000", trap_valid_o, trap_pc_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h1000) begin
        errs++; $display("FAIL exc_hold%0d: got valid=%b pc=%h expected 1/00001000", i, trap_valid_o, trap_pc_o); end
    end
    trap_ack_i = 1'b1;
    @(posedge clk); #1;
    trap_ack_i = 1'b0;
    vecs++; if (trap_valid_o !== 1'b0 || csr_ready_o !== 1'b1) begin
      errs++; $display("FAIL exc_ack: got valid=%b ready=%b expected 0/1", trap_valid_o, csr_ready_o); end
    csr_op(2'b01, 12'h341, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h200) begin errs++; $display("FAIL exc_mepc: got %h expected 00000200", rd); end
    csr_op(2'b01, 12'h342, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h2) begin errs++; $display("FAIL exc_mcause: got %h expected 00000002", rd); end
    csr_op(2'b01, 12'h343, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'hDEAD) begin errs++; $display("FAIL exc_mtval: got %h expected 0000dead", rd); end
    csr_op(2'b01, 12'h300, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h1880) begin errs++; $display("FAIL exc_mstatus: got %h expected 00001880", rd); end
  endtask

  task automatic test_irq_vectored();
    csr_op(2'b10, 12'h305, 32'h00001001, rd, rv, ill);
    irq_i = 16'h0088; exception_pc_i = 32'h347;
    csr_op(2'b10, 12'h304, 32'h00000088, rd, rv, ill);
    csr_op(2'b10, 12'h300, 32'h00000008, rd, rv, ill);
    @(posedge clk); #1;
    vecs++; if (trap_valid_o !== 1'b0) begin errs++; $display("FAIL irq_save: got %b expected 0", trap_valid_o); end
    @(posedge clk); #1;
    vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h101C) begin
      errs++; $display("FAIL irq_target: got valid=%b pc=%h expected 1/0000101c", trap_valid_o, trap_pc_o); end
    trap_ack_i = 1'b1; irq_i = 16'h0;
    @(posedge clk); #1;
    trap_ack_i = 1'b0;
    csr_op(2'b01, 12'h342, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h80000007) begin errs++; $display("FAIL irq_mcause: got %h expected 80000007", rd); end
    csr_op(2'b01, 12'h341, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h344) begin errs++; $display("FAIL irq_mepc: got %h expected 00000344", rd); end
    csr_op(2'b01, 12'h343, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL irq_mtval: got %h expected 0", rd); end
    mret_i = 1'b1;
    #1;
    vecs++; if (csr_ready_o !== 1'b0) begin errs++; $display("FAIL mret_ready: got %b expected 0", csr_ready_o); end
    @(posedge clk); #1;
    mret_i = 1'b0; trap_ack_i = 1'b1;
    vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h344) begin
      errs++; $display("FAIL mret_n1: got valid=%b pc=%h expected 1/00000344", trap_valid_o, trap_pc_o); end
    @(posedge clk); #1;
    trap_ack_i = 1'b0;
    vecs++; if (trap_valid_o !== 1'b0) begin errs++; $display("FAIL mret_1cycle: got %b expected 0", trap_valid_o); end
    csr_op(2'b01, 12'h300, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h1888) begin errs++; $display("FAIL mret_mstatus: got %h expected 00001888", rd); end
  endtask

  task automatic test_back_to_back();
    csr_op(2'b10, 12'h305, 32'h00001000, rd, rv, ill);
    exception_i = 1'b1; mret_i = 1'b1; exception_cause_i = 5'd5; exception_pc_i = 32'h400; exception_tval_i = 32'h11;
    csr_command_i = 2'b10; csr_address_i = 12'h340; csr_write_data_i = 32'hFFFF;
    #1;
    vecs++; if (csr_ready_o !== 1'b0) begin errs++; $display("FAIL simul_ready: got %b expected 0", csr_ready_o); end
    @(posedge clk); #1;
    exception_i = 1'b0; mret_i = 1'b0; csr_command_i = 2'b00;
    vecs++; if (trap_valid_o !== 1'b0) begin errs++; $display("FAIL simul_save: got %b expected 0", trap_valid_o); end
    @(posedge clk); #1;
    vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h1000) begin
      errs++; $display("FAIL simul_target: got valid=%b pc=%h expected 1/00001000", trap_valid_o, trap_pc_o); end
    trap_ack_i = 1'b1;
    @(posedge clk); #1;
    trap_ack_i = 1'b0;
    csr_op(2'b01, 12'h340, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h1) begin errs++; $display("FAIL simul_dropped: got %h expected 00000001", rd); end
    csr_op(2'b01, 12'h342, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h5) begin errs++; $display("FAIL simul_mcause: got %h expected 00000005", rd); end
    csr_op(2'b01, 12'h300, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h1880) begin errs++; $display("FAIL simul_mstatus: got %h expected 00001880", rd); end
    mret_i = 1'b1;
    @(posedge clk); #1;
    mret_i = 1'b0;
    vecs++; if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h400) begin
      errs++; $display("FAIL rst_pre: got valid=%b pc=%h expected 1/00000400", trap_valid_o, trap_pc_o); end
    reset_i = 1'b1;
    #1;
    vecs++; if (trap_valid_o !== 1'b0 || trap_pc_o !== 32'h0) begin
      errs++; $display("FAIL rst_async: got valid=%b pc=%h expected 0/0", trap_valid_o, trap_pc_o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    csr_op(2'b01, 12'h300, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h1800) begin errs++; $display("FAIL rst_mstatus: got %h expected 00001800", rd); end
    csr_op(2'b01, 12'h341, 32'd0, rd, rv, ill);
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL rst_mepc: got %h expected 0", rd); end
  endtask

  initial begin
    reset_i = 1'b1; csr_address_i = 12'h0; csr_command_i = 2'b00; csr_write_data_i = 32'h0;
    exception_i = 1'b0; exception_cause_i = 5'd0; exception_pc_i = 32'h0; exception_tval_i = 32'h0;
    mret_i = 1'b0; irq_i = 16'h0; trap_ack_i = 1'b0;
    test_reset();
    test_rw_scratch();
    test_mtvec_mode();
    test_illegal();
    test_exception();
    test_irq_vectored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
